// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: opcode encodings, CPU state codes
// and the internal ALU operation set.
package ex_stage_pkg;

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_JMPR  = 5'b11001;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;

    typedef enum logic [3:0] {
        ALU_ZERO,
        ALU_ADD,
        ALU_ADDC,
        ALU_SUB,
        ALU_SUBC,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_PASSB
    } alu_op_e;

endpackage

// File: rtl/ex_stage_alu16.sv
// Combinational 16-bit ALU for the execute stage. With EX_OVF_EN defined it
// also reports signed overflow on vf for the add/subtract operations.
module alu16
    import ex_stage_pkg::*;
(
    input  alu_op_e     op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] result,
    output logic        cout
`ifdef EX_OVF_EN
    ,
    output logic        vf
`endif
);

    logic [16:0] sum;
    logic        is_add;
    logic        is_sub;

    always_comb begin
        sum    = '0;
        result = '0;
        cout   = 1'b0;
        is_add = 1'b0;
        is_sub = 1'b0;
        case (op)
            ALU_ADD:   begin sum = {1'b0, a} + {1'b0, b};                 is_add = 1'b1; end
            ALU_ADDC:  begin sum = {1'b0, a} + {1'b0, b} + {16'h0, cin};  is_add = 1'b1; end
            // bit 16 of the 17-bit difference is the borrow
            ALU_SUB:   begin sum = {1'b0, a} - {1'b0, b};                 is_sub = 1'b1; end
            ALU_SUBC:  begin sum = {1'b0, a} - {1'b0, b} - {16'h0, cin};  is_sub = 1'b1; end
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_SLL:   result = a << b[3:0];
            ALU_SRL:   result = a >> b[3:0];
            ALU_SRA:   result = $signed(a) >>> b[3:0];
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
        if (is_add || is_sub) begin
            result = sum[15:0];
            cout   = sum[16];
        end
    end

`ifdef EX_OVF_EN
    always_comb begin
        vf = 1'b0;
        if (is_add)
            vf = (a[15] == b[15]) && (result[15] != a[15]);
        else if (is_sub)
            vf = (a[15] != b[15]) && (result[15] != a[15]);
    end
`endif

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand selection, ALU, NF/ZF/CF flags, branch decision and
// the registers feeding the memory stage. Define EX_OVF_EN to add the vf flag.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [1:0]    state,
    input  logic [DW-1:0] ex_ir,
    input  logic [DW-1:0] reg_A,
    input  logic [DW-1:0] reg_B,
    input  logic [DW-1:0] smdr,
    output logic [DW-1:0] mem_ir,
    output logic [DW-1:0] reg_C,
    output logic [AW-1:0] d_addr,
    output logic [DW-1:0] d_dataout,
    output logic          d_we,
    output logic          branch_flag,
    output logic          nf,
    output logic          zf,
    output logic          cf
`ifdef EX_OVF_EN
    ,
    output logic          vf
`endif
);

    logic [4:0]  op;
    alu_op_e     alu_op;
    logic [15:0] op_b;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        flag_wr;
    logic        taken;
    logic        exec;

    assign op   = ex_ir[15:11];
    assign exec = (state == ST_EXEC);

    always_comb begin
        alu_op  = ALU_ZERO;
        op_b    = '0;
        flag_wr = 1'b0;
        taken   = 1'b0;
        case (op)
            OP_ADD:  begin alu_op = ALU_ADD;  op_b = reg_B; flag_wr = 1'b1; end
            OP_ADDC: begin alu_op = ALU_ADDC; op_b = reg_B; flag_wr = 1'b1; end
            OP_SUB,
            OP_CMP:  begin alu_op = ALU_SUB;  op_b = reg_B; flag_wr = 1'b1; end
            OP_SUBC: begin alu_op = ALU_SUBC; op_b = reg_B; flag_wr = 1'b1; end
            OP_AND:  begin alu_op = ALU_AND;  op_b = reg_B; flag_wr = 1'b1; end
            OP_OR:   begin alu_op = ALU_OR;   op_b = reg_B; flag_wr = 1'b1; end
            OP_XOR:  begin alu_op = ALU_XOR;  op_b = reg_B; flag_wr = 1'b1; end
            OP_ADDI: begin alu_op = ALU_ADD;  op_b = {8'h00, ex_ir[7:0]}; flag_wr = 1'b1; end
            OP_SUBI: begin alu_op = ALU_SUB;  op_b = {8'h00, ex_ir[7:0]}; flag_wr = 1'b1; end
            OP_LDIH: begin alu_op = ALU_ADD;  op_b = {ex_ir[7:0], 8'h00}; flag_wr = 1'b1; end
            OP_SLL,
            OP_SLA:  begin alu_op = ALU_SLL;  op_b = {12'h000, ex_ir[3:0]}; flag_wr = 1'b1; end
            OP_SRL:  begin alu_op = ALU_SRL;  op_b = {12'h000, ex_ir[3:0]}; flag_wr = 1'b1; end
            OP_SRA:  begin alu_op = ALU_SRA;  op_b = {12'h000, ex_ir[3:0]}; flag_wr = 1'b1; end
            OP_LOAD,
            OP_STORE: begin alu_op = ALU_ADD; op_b = {12'h000, ex_ir[3:0]}; end
            OP_JUMP: begin alu_op = ALU_PASSB; op_b = {8'h00, ex_ir[7:0]}; taken = 1'b1; end
            // conditional branches look at the flags left by the previous instruction
            OP_JMPR: begin alu_op = ALU_ADD; op_b = {8'h00, ex_ir[7:0]}; taken = 1'b1; end
            OP_BZ:   begin alu_op = ALU_ADD; op_b = {8'h00, ex_ir[7:0]}; taken = zf;  end
            OP_BNZ:  begin alu_op = ALU_ADD; op_b = {8'h00, ex_ir[7:0]}; taken = !zf; end
            OP_BN:   begin alu_op = ALU_ADD; op_b = {8'h00, ex_ir[7:0]}; taken = nf;  end
            OP_BNN:  begin alu_op = ALU_ADD; op_b = {8'h00, ex_ir[7:0]}; taken = !nf; end
            OP_BC:   begin alu_op = ALU_ADD; op_b = {8'h00, ex_ir[7:0]}; taken = cf;  end
            OP_BNC:  begin alu_op = ALU_ADD; op_b = {8'h00, ex_ir[7:0]}; taken = !cf; end
            default: begin alu_op = ALU_ZERO; op_b = '0; end
        endcase
    end

`ifdef EX_OVF_EN
    logic alu_vf;
    logic vf_wr;

    always_comb begin
        vf_wr = 1'b0;
        case (op)
            OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP: vf_wr = 1'b1;
            default: vf_wr = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            vf <= 1'b0;
        else if (exec && vf_wr)
            vf <= alu_vf;
    end
`endif

    alu16 u_alu (
        .op     (alu_op),
        .a      (reg_A),
        .b      (op_b),
        .cin    (cf),
        .result (alu_result),
        .cout   (alu_cout)
`ifdef EX_OVF_EN
        ,
        .vf     (alu_vf)
`endif
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_ir      <= '0;
            reg_C       <= '0;
            d_addr      <= '0;
            d_dataout   <= '0;
            d_we        <= 1'b0;
            branch_flag <= 1'b0;
            nf          <= 1'b0;
            zf          <= 1'b0;
            cf          <= 1'b0;
        end else if (exec) begin
            mem_ir      <= ex_ir;
            reg_C       <= alu_result;
            d_addr      <= alu_result[AW-1:0];
            d_dataout   <= smdr;
            d_we        <= (op == OP_STORE);
            branch_flag <= taken;
            if (flag_wr) begin
                nf <= alu_result[15];
                zf <= (alu_result == 16'h0000);
                cf <= alu_cout;
            end
        end else begin
            d_we        <= 1'b0;
            branch_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Randomized scoreboard bench for ex_stage: a driver feeds directed then random
// cycles and queues predictions from an arithmetic reference model; a monitor pops and compares.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] c;
        logic [7:0]  addr;
        logic [15:0] dout;
        logic        we;
        logic        br;
        logic        nf;
        logic        zf;
        logic        cf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  state;
    logic [15:0] ex_ir, reg_A, reg_B, smdr;
    logic [15:0] mem_ir, reg_C, d_dataout;
    logic [7:0]  d_addr;
    logic        d_we, branch_flag, nf, zf, cf;
`ifdef EX_OVF_EN
    logic        vf;
`endif

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t m_out;
    logic m_nf, m_zf, m_cf;

    logic [4:0] op_list [27] = '{OP_NOP, OP_HALT, OP_LOAD, OP_STORE, OP_LDIH, OP_ADD,
        OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR,
        OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_JUMP, OP_JMPR, OP_BZ, OP_BNZ, OP_BN,
        OP_BNN, OP_BC, OP_BNC};

    always #5 clock = ~clock;

    ex_stage #(.DW(16), .AW(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .state       (state),
        .ex_ir       (ex_ir),
        .reg_A       (reg_A),
        .reg_B       (reg_B),
        .smdr        (smdr),
        .mem_ir      (mem_ir),
        .reg_C       (reg_C),
        .d_addr      (d_addr),
        .d_dataout   (d_dataout),
        .d_we        (d_we),
        .branch_flag (branch_flag),
        .nf          (nf),
        .zf          (zf),
        .cf          (cf)
`ifdef EX_OVF_EN
        ,
        .vf          (vf)
`endif
    );

    // Reference model: what the memory stage should see after one clock edge
    task automatic model_step(input logic rst, input logic [1:0] st, input logic [4:0] op,
                              input logic [10:0] low, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] sd);
        int ua, ub, imm8, imm4, r, sa;
        logic fw, take, ncf;
        logic [15:0] res;
        ua = int'(a); ub = int'(b); imm8 = int'(low[7:0]); imm4 = int'(low[3:0]);
        r = 0; fw = 1'b0; take = 1'b0; ncf = 1'b0;
        if (rst) begin
            m_out = '0;
            m_nf = 1'b0; m_zf = 1'b0; m_cf = 1'b0;
        end else if (st != ST_EXEC) begin
            m_out.we = 1'b0;
            m_out.br = 1'b0;
        end else begin
            case (op)
                OP_ADD:  begin r = ua + ub;                fw = 1; ncf = (r > 65535); end
                OP_ADDC: begin r = ua + ub + int'(m_cf);   fw = 1; ncf = (r > 65535); end
                OP_ADDI: begin r = ua + imm8;              fw = 1; ncf = (r > 65535); end
                OP_LDIH: begin r = ua + imm8 * 256;        fw = 1; ncf = (r > 65535); end
                OP_SUB,
                OP_CMP:  begin r = ua - ub;                fw = 1; ncf = (r < 0); end
                OP_SUBC: begin r = ua - ub - int'(m_cf);   fw = 1; ncf = (r < 0); end
                OP_SUBI: begin r = ua - imm8;              fw = 1; ncf = (r < 0); end
                OP_AND:  begin r = ua & ub;                fw = 1; end
                OP_OR:   begin r = ua | ub;                fw = 1; end
                OP_XOR:  begin r = ua ^ ub;                fw = 1; end
                OP_SLL,
                OP_SLA:  begin r = ua * (1 << imm4);       fw = 1; end
                OP_SRL:  begin r = ua / (1 << imm4);       fw = 1; end
                OP_SRA:  begin
                    sa = (ua >= 32768) ? ua - 65536 : ua;
                    r  = sa >>> imm4;
                    fw = 1;
                end
                OP_LOAD,
                OP_STORE: r = ua + imm4;
                OP_JUMP: begin r = imm8;      take = 1'b1; end
                OP_JMPR: begin r = ua + imm8; take = 1'b1; end
                OP_BZ:   begin r = ua + imm8; take = m_zf;  end
                OP_BNZ:  begin r = ua + imm8; take = !m_zf; end
                OP_BN:   begin r = ua + imm8; take = m_nf;  end
                OP_BNN:  begin r = ua + imm8; take = !m_nf; end
                OP_BC:   begin r = ua + imm8; take = m_cf;  end
                OP_BNC:  begin r = ua + imm8; take = !m_cf; end
                default: r = 0;
            endcase
            res = 16'(r);
            m_out.ir   = {op, low};
            m_out.c    = res;
            m_out.addr = res[7:0];
            m_out.dout = sd;
            m_out.we   = (op == OP_STORE);
            m_out.br   = take;
            if (fw) begin
                m_nf = res[15];
                m_zf = (res == 16'h0000);
                m_cf = ncf;
            end
        end
        m_out.nf = m_nf; m_out.zf = m_zf; m_out.cf = m_cf;
    endtask

    task automatic drive(input logic rst, input logic [1:0] st, input logic [4:0] op,
                         input logic [10:0] low, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] sd);
        @(negedge clock);
        #1;
        reset = rst; state = st; ex_ir = {op, low};
        reg_A = a; reg_B = b; smdr = sd;
        model_step(rst, st, op, low, a, b, sd);
        exp_q.push_back(m_out);
    endtask

    function automatic logic [15:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 16'hFFFF;
            1: return 16'h0000;
            2: return 16'h8000;
            3: return 16'h7FFF;
            4: return 16'h0001;
            default: return 16'($urandom());
        endcase
    endfunction

    // Monitor: one registered output vector per queued prediction
    initial begin
        exp_t e, act;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {mem_ir, reg_C, d_addr, d_dataout, d_we, branch_flag, nf, zf, cf};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL stage_out @%0t: got ir=%h c=%h addr=%h dout=%h we=%b br=%b nzc=%b%b%b, want ir=%h c=%h addr=%h dout=%h we=%b br=%b nzc=%b%b%b",
                             $time, act.ir, act.c, act.addr, act.dout, act.we, act.br, act.nf, act.zf, act.cf,
                             e.ir, e.c, e.addr, e.dout, e.we, e.br, e.nf, e.zf, e.cf);
                end
            end
        end
    end

    initial begin
        logic [1:0] st;
        logic       rst;
        int         wait_cycles;
        reset = 1'b1; state = ST_IDLE; ex_ir = '0; reg_A = '0; reg_B = '0; smdr = '0;

        drive(1, ST_IDLE, OP_NOP, 11'h0, 16'h0, 16'h0, 16'h0);
        drive(1, ST_EXEC, OP_ADD, 11'h123, 16'h1234, 16'h1111, 16'h5555);
        drive(0, ST_IDLE, OP_NOP, 11'h0, 16'h0, 16'h0, 16'h0);
        // carry-out to zero, then ADDC consuming it, then BC on cleared carry
        drive(0, ST_EXEC, OP_ADD,  {3'd1, 4'd2, 4'd3}, 16'hFFFF, 16'h0001, 16'h0);
        drive(0, ST_EXEC, OP_ADDC, {3'd1, 4'd2, 4'd3}, 16'h0002, 16'h0003, 16'h0);
        drive(0, ST_EXEC, OP_BC,   {3'd1, 8'h10},      16'h0020, 16'h0000, 16'h0);
        // STORE pulse, then back-to-back STOREs
        drive(0, ST_EXEC, OP_STORE, {3'd2, 4'd0, 4'd4}, 16'h0040, 16'h0, 16'hBEEF);
        drive(0, ST_EXEC, OP_NOP,   11'h0, 16'h0, 16'h0, 16'h0);
        drive(0, ST_EXEC, OP_STORE, {3'd3, 4'd0, 4'd1}, 16'h0010, 16'h0, 16'hCAFE);
        drive(0, ST_EXEC, OP_STORE, {3'd3, 4'd0, 4'd2}, 16'h0010, 16'h0, 16'hF00D);
        drive(0, ST_EXEC, OP_SRA, {3'd1, 4'd0, 4'd4}, 16'h8000, 16'h0, 16'h0);
        drive(0, ST_EXEC, OP_SRL, {3'd1, 4'd0, 4'd4}, 16'h8000, 16'h0, 16'h0);
        drive(0, ST_EXEC, OP_JUMP, {3'd0, 8'hA5}, 16'h1234, 16'h0, 16'h0);
        // idle with STORE presented, then reset mid-exec
        drive(0, ST_IDLE, OP_STORE, {3'd2, 4'd0, 4'd7}, 16'h0100, 16'h0, 16'h1357);
        drive(0, ST_EXEC, OP_STORE, {3'd2, 4'd0, 4'd7}, 16'h0100, 16'h0, 16'h1357);
        drive(1, ST_EXEC, OP_ADD,   11'h0, 16'hFFFF, 16'h0001, 16'h0);
        drive(0, ST_EXEC, OP_ADD,   11'h0, 16'h7FFF, 16'h0001, 16'h0);

        for (int i = 0; i < 600; i++) begin
            st  = ($urandom_range(0, 9) == 0) ? ST_IDLE : ST_EXEC;
            rst = ($urandom_range(0, 80) == 0);
            drive(rst, st, op_list[$urandom_range(0, 26)], 11'($urandom()),
                  pick_val(), pick_val(), 16'($urandom()));
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d predictions left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
